// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU op classes and the control bundle the decoder produces.
package riscv_ctrl_pkg;

   localparam int unsigned OP_W    = 7;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned CNT_W   = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_FAULT  = 3'd6
   } state_e;

   localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_LD = 7'b0000011;
   localparam logic [OP_W-1:0] OP_ST = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BR = 7'b1100011;

   localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
   localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

   typedef struct packed {
      logic               pc_write;
      logic               pc_src;
      logic               ir_write;
      logic               alusrc;
      logic               memread;
      logic               memwrite;
      logic               memtoreg;
      logic               regwrite;
      logic [ALUOP_W-1:0] aluop;
      logic               retire;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
   endfunction

   function automatic logic [ALUOP_W-1:0] aluop_of(input logic [OP_W-1:0] op);
      logic [ALUOP_W-1:0] a;
      a = ALUOP_MEM;
      if (op == OP_BR) a = ALUOP_BR;
      else if (op == OP_R) a = ALUOP_R;
      else if (op == OP_I) a = ALUOP_I;
      return a;
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus latched opcode (and the
// few live handshakes) to datapath controls and the retire strobe.
module mc_ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  state_e            state,
   input  logic [OP_W-1:0]   op,
   input  logic              branch_taken,
   input  logic              mem_ready,
   input  logic              stop_req,
   output ctrl_t             ctrl
);

   logic is_ld;
   logic is_st;
   logic is_br;
   logic op_alusrc;

   assign is_ld     = (op == OP_LD);
   assign is_st     = (op == OP_ST);
   assign is_br     = (op == OP_BR);
   assign op_alusrc = (op == OP_I) || is_ld || is_st;

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            // a pending stop leaves FETCH without loading a new instruction
            ctrl.ir_write = ~stop_req;
         end
         ST_EXEC: begin
            ctrl.aluop  = aluop_of(op);
            ctrl.alusrc = op_alusrc;
            if (is_br) begin
               ctrl.pc_write = 1'b1;
               ctrl.pc_src   = branch_taken;
               ctrl.retire   = 1'b1;
            end
         end
         ST_MEM: begin
            ctrl.aluop    = aluop_of(op);
            ctrl.alusrc   = op_alusrc;
            ctrl.memread  = is_ld;
            ctrl.memwrite = is_st;
            if (mem_ready && is_st) begin
               ctrl.pc_write = 1'b1;
               ctrl.retire   = 1'b1;
            end
         end
         ST_WB: begin
            ctrl.aluop    = aluop_of(op);
            ctrl.alusrc   = op_alusrc;
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = is_ld;
            ctrl.pc_write = 1'b1;
            ctrl.retire   = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style controller: FSM, memory timeout and performance
// counters; control decode lives in mc_ctrl_decode.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [OP_W-1:0]      opcode,
   input  logic                 branch_taken,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 ir_write,
   output logic                 alusrc,
   output logic                 memread,
   output logic                 memwrite,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic [ALUOP_W-1:0]   aluop,
   output logic                 busy,
   output logic                 fault,
   output logic [2:0]           state,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     instret
);

   localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

   state_e            state_q;
   logic [OP_W-1:0]   op_q;
   logic [TMO_W-1:0]  tmo_q;
   logic              stop_q;
   logic              stop_req;
   ctrl_t             ctrl;

   assign stop_req = stop | stop_q;
   assign busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                     (state_q == ST_MEM) || (state_q == ST_WB);
   assign fault    = (state_q == ST_FAULT);
   assign state    = state_q;

   mc_ctrl_decode u_decode (
      .state        (state_q),
      .op           (op_q),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .stop_req     (stop_req),
      .ctrl         (ctrl)
   );

   assign pc_write = ctrl.pc_write;
   assign pc_src   = ctrl.pc_src;
   assign ir_write = ctrl.ir_write;
   assign alusrc   = ctrl.alusrc;
   assign memread  = ctrl.memread;
   assign memwrite = ctrl.memwrite;
   assign memtoreg = ctrl.memtoreg;
   assign regwrite = ctrl.regwrite;
   assign aluop    = ctrl.aluop;

   // FSM, memory timeout, stop request latch and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         tmo_q       <= '0;
         stop_q      <= 1'b0;
         cycle_count <= '0;
         instret     <= '0;
      end else begin
         if (busy) cycle_count <= cycle_count + CNT_W'(1);
         if (ctrl.retire) instret <= instret + CNT_W'(1);
         // stop seen mid-instruction is honoured at the next FETCH
         if (stop && busy) stop_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               stop_q <= 1'b0;
               if (start) state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (stop_req) begin
                  stop_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               op_q    <= opcode;
               state_q <= is_legal_op(opcode) ? ST_EXEC : ST_FAULT;
            end
            ST_EXEC: begin
               if (op_q == OP_BR) begin
                  state_q <= ST_FETCH;
               end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
                  tmo_q   <= '0;
                  state_q <= ST_MEM;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MEM: begin
               // ready on the final allowed cycle still completes normally
               if (mem_ready) begin
                  state_q <= (op_q == OP_ST) ? ST_FETCH : ST_WB;
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= ST_FAULT;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            ST_WB:    state_q <= ST_FETCH;
            ST_FAULT: state_q <= ST_FAULT;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class,
// timeout boundary, illegal opcode, reset mid-MEM and stop handling.
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        mem_ready;
   logic        pc_write, pc_src, ir_write, alusrc, memread, memwrite, memtoreg, regwrite;
   logic [1:0]  aluop;
   logic        busy, fault;
   logic [2:0]  state;
   logic [63:0] cycle_count, instret;

   int total;
   int bad;

   multicycle_controller #(.MEM_TIMEOUT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .ir_write     (ir_write),
      .alusrc       (alusrc),
      .memread      (memread),
      .memwrite     (memwrite),
      .memtoreg     (memtoreg),
      .regwrite     (regwrite),
      .aluop        (aluop),
      .busy         (busy),
      .fault        (fault),
      .state        (state),
      .cycle_count  (cycle_count),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; opcode = 7'b0110011;
      branch_taken = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_state", 64'(state), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_instret", instret, 0);
      reset = 1'b0;

      // R-type
      start = 1'b1;
      tick(); start = 1'b0; #1;
      chk("r_fetch_state", 64'(state), 1);
      chk("r_fetch_irw", 64'(ir_write), 1);
      chk("r_fetch_busy", 64'(busy), 1);
      tick(); #1;
      chk("r_decode_state", 64'(state), 2);
      chk("r_decode_irw", 64'(ir_write), 0);
      tick(); opcode = 7'b1111111; #1;
      chk("r_exec_state", 64'(state), 3);
      chk("r_exec_aluop", 64'(aluop), 2);
      chk("r_exec_alusrc", 64'(alusrc), 0);
      chk("r_exec_regw", 64'(regwrite), 0);
      tick(); #1;
      chk("r_wb_state", 64'(state), 5);
      chk("r_wb_regw", 64'(regwrite), 1);
      chk("r_wb_memtoreg", 64'(memtoreg), 0);
      chk("r_wb_pcw", 64'(pc_write), 1);
      chk("r_wb_aluop", 64'(aluop), 2);
      tick(); opcode = 7'b0000011; #1;
      chk("r_ret_state", 64'(state), 1);
      chk("r_ret_instret", instret, 1);
      chk("r_ret_cycles", cycle_count, 4);

      // LD with ready on third MEM cycle
      tick(); #1;
      chk("ld_decode", 64'(state), 2);
      tick(); #1;
      chk("ld_exec_aluop", 64'(aluop), 0);
      chk("ld_exec_alusrc", 64'(alusrc), 1);
      tick(); #1;
      chk("ld_mem1_state", 64'(state), 4);
      chk("ld_mem1_rd", 64'(memread), 1);
      tick(); #1;
      chk("ld_mem2_rd", 64'(memread), 1);
      tick(); mem_ready = 1'b1; #1;
      chk("ld_mem3_rd", 64'(memread), 1);
      chk("ld_mem3_pcw", 64'(pc_write), 0);
      tick(); mem_ready = 1'b0; #1;
      chk("ld_wb_state", 64'(state), 5);
      chk("ld_wb_memtoreg", 64'(memtoreg), 1);
      chk("ld_wb_regw", 64'(regwrite), 1);
      chk("ld_wb_rd", 64'(memread), 0);
      tick(); opcode = 7'b1100011; #1;
      chk("ld_ret_instret", instret, 2);
      chk("ld_ret_cycles", cycle_count, 11);

      // branch taken then not taken
      tick(); #1;
      tick(); branch_taken = 1'b1; #1;
      chk("brt_state", 64'(state), 3);
      chk("brt_pcw", 64'(pc_write), 1);
      chk("brt_pcsrc", 64'(pc_src), 1);
      chk("brt_regw", 64'(regwrite), 0);
      chk("brt_aluop", 64'(aluop), 1);
      tick(); branch_taken = 1'b0; #1;
      chk("brt_ret_state", 64'(state), 1);
      chk("brt_ret_pcw", 64'(pc_write), 0);
      chk("brt_instret", instret, 3);
      tick(); #1;
      tick(); #1;
      chk("brn_pcw", 64'(pc_write), 1);
      chk("brn_pcsrc", 64'(pc_src), 0);
      chk("brn_regw", 64'(regwrite), 0);
      tick(); opcode = 7'b0100011; #1;
      chk("brn_instret", instret, 4);
      chk("brn_cycles", cycle_count, 17);

      // ST with ready on the 16th MEM cycle
      tick(); #1;
      tick(); #1;
      chk("st_exec_alusrc", 64'(alusrc), 1);
      tick(); #1;
      chk("st_mem1_wr", 64'(memwrite), 1);
      for (int i = 2; i <= 15; i++) tick();
      #1;
      chk("st_mem15_state", 64'(state), 4);
      chk("st_mem15_wr", 64'(memwrite), 1);
      tick(); mem_ready = 1'b1; #1;
      chk("st_mem16_state", 64'(state), 4);
      chk("st_mem16_wr", 64'(memwrite), 1);
      chk("st_mem16_pcw", 64'(pc_write), 1);
      chk("st_mem16_pcsrc", 64'(pc_src), 0);
      tick(); mem_ready = 1'b0; #1;
      chk("st_ret_state", 64'(state), 1);
      chk("st_ret_instret", instret, 5);
      chk("st_ret_cycles", cycle_count, 36);

      // ST timeout
      tick(); #1;
      tick(); #1;
      tick(); #1;
      for (int i = 2; i <= 16; i++) tick();
      #1;
      chk("sto_mem16_state", 64'(state), 4);
      chk("sto_mem16_wr", 64'(memwrite), 1);
      tick(); start = 1'b1; #1;
      chk("sto_fault_state", 64'(state), 6);
      chk("sto_fault_flag", 64'(fault), 1);
      chk("sto_fault_wr", 64'(memwrite), 0);
      chk("sto_fault_busy", 64'(busy), 0);
      repeat (3) tick();
      start = 1'b0; #1;
      chk("sto_frozen_state", 64'(state), 6);
      chk("sto_frozen_cycles", cycle_count, 55);
      chk("sto_frozen_instret", instret, 5);

      // illegal opcode
      reset = 1'b1; #3; reset = 1'b0;
      start = 1'b1; opcode = 7'b1111111;
      tick(); start = 1'b0; #1;
      tick(); #1;
      tick(); #1;
      chk("ill_state", 64'(state), 6);
      chk("ill_fault", 64'(fault), 1);
      chk("ill_cycles", cycle_count, 2);
      chk("ill_instret", instret, 0);

      // reset asserted mid-MEM
      reset = 1'b1; #3; reset = 1'b0;
      start = 1'b1; opcode = 7'b0000011;
      tick(); start = 1'b0; #1;
      tick(); tick(); tick(); #1;
      chk("rm_mem_state", 64'(state), 4);
      chk("rm_mem_rd", 64'(memread), 1);
      reset = 1'b1; #1;
      chk("rm_state", 64'(state), 0);
      chk("rm_rd", 64'(memread), 0);
      chk("rm_busy", 64'(busy), 0);
      chk("rm_cycles", cycle_count, 0);
      #2; reset = 1'b0;

      // stop during WB
      start = 1'b1; opcode = 7'b0110011;
      tick(); start = 1'b0; #1;
      tick(); tick(); tick(); stop = 1'b1; #1;
      chk("stop_wb_state", 64'(state), 5);
      tick(); stop = 1'b0; #1;
      chk("stop_fetch_state", 64'(state), 1);
      chk("stop_fetch_irw", 64'(ir_write), 0);
      chk("stop_fetch_instret", instret, 1);
      tick(); #1;
      chk("stop_idle_state", 64'(state), 0);
      chk("stop_idle_busy", 64'(busy), 0);
      chk("stop_idle_instret", instret, 1);
      tick(); #1;
      chk("stop_idle_cycles", cycle_count, 5);
      chk("stop_idle_hold", 64'(state), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum cycles in MEM without mem_ready before FAULT.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin execution from IDLE.
REQ-005 stop  input  1  return to IDLE at next instruction boundary.
REQ-006 opcode  input  7  instruction[6:0] from instruction parser.
REQ-007 branch_taken  input  1  branch-unit condition result.
REQ-008 mem_ready  input  1  data memory completion strobe.
REQ-009 pc_write, pc_src, ir_write  output  1 each  PC load enable; PC mux select (0 = PC+4, 1 = branch target); instruction register load.
REQ-010 alusrc, memread, memwrite, memtoreg, regwrite  output  1 each  datapath controls, same meaning as control_unit outputs.
REQ-011 aluop  output  2  ALU-control op class.
REQ-012 busy, fault  output  1 each  executing; sticky illegal-opcode/timeout flag.
REQ-013 state  output  3  current FSM state encoding.
REQ-014 cycle_count, instret  output  64 each  active-cycle and retired-instruction counters.

Function
REQ-015 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6; encoding 7 unreachable, recovers to IDLE.
REQ-016 IDLE: start=1 -> FETCH; otherwise hold.
REQ-017 FETCH: stop=1 -> IDLE with no outputs asserted; else ir_write=1 for exactly one cycle -> DECODE.
REQ-018 DECODE: latch opcode into internal register; legal {0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BR} -> EXEC; any other -> FAULT.
REQ-019 All controls after DECODE are combinational functions of state and latched opcode only; opcode input changes after DECODE have no effect.
REQ-020 aluop: LD/ST 00, BR 01, R 10, I 11; alusrc=1 for I/LD/ST, 0 for R/BR; both held stable EXEC through WB.
REQ-021 EXEC: R/I -> WB; LD/ST -> MEM; BR -> pc_write=1, pc_src=branch_taken, retire, -> FETCH.
REQ-022 MEM: memread (LD) or memwrite (ST) held asserted every MEM cycle until mem_ready sampled 1.
REQ-023 MEM with mem_ready=1: ST -> pc_write=1, pc_src=0, retire, -> FETCH; LD -> WB.
REQ-024 MEM timeout counter clears on MEM entry; after MEM_TIMEOUT consecutive MEM cycles with mem_ready=0 -> FAULT, no write issued further.
REQ-025 mem_ready in the same cycle as the timeout limit: ready wins, no FAULT.
REQ-026 WB: regwrite=1, memtoreg=1 for LD else 0, pc_write=1, pc_src=0, retire, -> FETCH; exactly one cycle.
REQ-027 FAULT: fault=1, all controls 0, counters frozen; exits only by reset.
REQ-028 busy=1 in FETCH..WB; 0 in IDLE and FAULT.
REQ-029 cycle_count increments each cycle busy=1; instret increments once per retire; both wrap 2^64-1 -> 0.
REQ-030 Controls pc_write, ir_write, regwrite, memwrite never asserted outside the states above; at most one retire per instruction.

Reset
REQ-031 Reset (async, any state, including mid-MEM) forces IDLE, all outputs 0, counters 0, timeout counter 0, latched opcode 0 within the same cycle.
REQ-032 First transition out of IDLE occurs on the first rising edge after reset deassertion with start=1.

Structure
REQ-033 Shared package riscv_ctrl_pkg holds state encodings, the five opcode constants and aluop constants.
REQ-034 One sub-module mc_ctrl_decode: combinational state+opcode -> control outputs; FSM, timeout and counters stay in the top.

Verification
REQ-035 R-type (0110011), start pulse: states 1,2,3,5,1; regwrite=1 only in WB; instret=1, cycle_count=4 at return to FETCH.
REQ-036 LD (0000011), mem_ready after 3 MEM cycles: memread high 3 cycles, WB with memtoreg=1, regwrite=1; instret=1.
REQ-037 BR (1100011) branch_taken=1 in EXEC: pc_write=1, pc_src=1 one cycle, regwrite never asserted; branch_taken=0 gives pc_src=0.
REQ-038 ST (0100011), mem_ready held 0, MEM_TIMEOUT=16: FAULT after 16 MEM cycles, fault=1, memwrite=0 thereafter, counters frozen; ready on 16th cycle -> normal retire.
REQ-039 Opcode 1111111 in DECODE -> FAULT; reset asserted mid-MEM -> IDLE, all outputs and counters 0 immediately.
REQ-040 stop=1 during WB of an instruction: next FETCH exits to IDLE, busy=0, instret counts the completed instruction.
